instr_fetch: RTL
================

Name: instr_fetch

Overview:
- Upstream stage of simple_cpu: holds a loadable program and drives the CPU's 20-bit instruction input.
- Program store is 32 x 20-bit, written through a load port while the block is idle.
- On start, it walks the PC from address 0 and presents each word for ISSUE_CYCLES clocks.
- It stops on a HALT opcode, at the end of memory, or on a stop request. Between instructions it drives NOP_INSTR.

Parameters:
- INSTR_WIDTH, 20, instruction word width.
- ADDR_BITS, 5, program address width (32 words).
- ISSUE_CYCLES, 3, clocks each instruction is held valid (>=1).
- HALT_OPCODE, 4'hF, value of instruction[INSTR_WIDTH-1 -: 4] that terminates the program.
- NOP_INSTR, 20'h00000, word driven whenever no instruction is issued.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-low.
- start  in  1  begin execution from address 0; honoured in IDLE/DONE only.
- stop  in  1  abort execution; honoured in FETCH/ISSUE only.
- load_en  in  1  program write strobe; honoured in IDLE/DONE only.
- load_addr  in  ADDR_BITS  program write address.
- load_data  in  INSTR_WIDTH  program write data.
- instruction  out  INSTR_WIDTH  word to simple_cpu.
- instr_valid  out  1  high while instruction carries a real program word.
- pc  out  ADDR_BITS  address of the word currently fetched or issued.
- busy  out  1  high in FETCH/ISSUE.
- done  out  1  high in DONE until the next start.

Behaviour:
- Reset (rst=0, async) forces:
  - state IDLE, pc=0, hold counter=0;
  - instruction=NOP_INSTR, instr_valid=0, busy=0, done=0.
  - Program memory contents are not cleared.
- States:
  - IDLE
    - load_en=1: mem[load_addr] <= load_data.
    - load_en=1 together with start=1: the load wins and start is ignored.
    - start=1 with load_en=0: pc <= 0, go to FETCH.
  - FETCH (1 cycle)
    - Synchronous read: rdata <= mem[pc]. Go to ISSUE with counter=0.
    - stop=1: go to DONE instead.
  - ISSUE
    - is_halt = rdata opcode field == HALT_OPCODE.
    - is_halt: instruction=NOP_INSTR, instr_valid=0, next state DONE. The HALT word is never issued.
    - Otherwise: instruction=rdata, instr_valid=1, counter increments each clock.
    - At counter==ISSUE_CYCLES-1 with pc<2^ADDR_BITS-1: pc++, go to FETCH.
    - At counter==ISSUE_CYCLES-1 with pc==2^ADDR_BITS-1: go to DONE. No wrap-around.
    - stop=1 in any ISSUE cycle: DONE at the next edge. The current word may have been valid for fewer than ISSUE_CYCLES clocks.
  - DONE
    - done=1, instruction=NOP_INSTR, pc holds its last value.
    - Loads are allowed, with the same load-over-start priority as IDLE.
    - start=1: pc <= 0, go to FETCH, done drops at that edge.
- Timing:
  - start sampled at edge E0 → first word valid from E1+ through E(1+ISSUE_CYCLES).
  - Steady rate is one instruction per ISSUE_CYCLES+1 clocks.
  - NOP gap of exactly one cycle (the FETCH cycle) between instructions.
- Output decoding:
  - instruction and instr_valid are decoded from registered state and rdata; no combinational path from inputs.
  - busy = (state==FETCH or ISSUE).
- Ignored inputs:
  - load_en during FETCH/ISSUE is ignored; memory is unchanged.
  - start while busy is ignored.
  - stop in IDLE/DONE is ignored.
- Reset mid-operation: outputs go to NOP/0 immediately (asynchronous), and the next run starts from address 0.

Decomposition:
- Package instr_fetch_pkg holds:
  - state encoding localparams S_IDLE, S_FETCH, S_ISSUE, S_DONE (2-bit);
  - opcode field width 4;
  - default HALT_OPCODE and NOP_INSTR values.
- One sub-module, prog_mem: 2^ADDR_BITS x INSTR_WIDTH.
  - One synchronous write port and one synchronous read port, no reset on the array.
- The top level contains the FSM, PC, hold counter and output mux.

Test Plan:
- Load mem[0..2] = 20'h1_0123, 20'h2_0456, 20'h3_0789 and mem[3] = 20'hF_0000; start with ISSUE_CYCLES=3 → each word valid for 3 clocks, 1-cycle NOP gaps, first valid at E1. After mem[3] is read: done=1, instruction=0, pc=3, and instr_valid is never high for the HALT word.
- mem[0] = 20'hF_1234, start → instr_valid stays 0, done=1 two edges after start, pc=0.
- All 32 words non-HALT (20'h1_0000+i), start → 32 instructions issued in order, done after word 31 with pc=31, no wrap to 0.
- stop asserted during the 2nd clock of word 1's ISSUE → DONE at the next edge, instruction=NOP, busy=0. A following start re-issues word 0.
- load_en with addr 0, data 20'h5_5555 during ISSUE → mem[0] unchanged on the next run. Same load in DONE with start=1 simultaneously → mem[0] updated, state stays DONE.
- rst pulled low mid-ISSUE (asynchronously, between edges) → instruction=0, instr_valid=0, busy=0, pc=0 immediately. Program retained: start after release reproduces the original sequence.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared encodings and defaults for the instruction fetch stage feeding simple_cpu.
package instr_fetch_pkg;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_ISSUE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int OPC_W = 4;

  localparam logic [OPC_W-1:0] DEF_HALT_OPCODE = 4'hF;
  localparam logic [19:0]      DEF_NOP_INSTR   = 20'h00000;
endpackage

// File: rtl/instr_fetch_if.sv
// Control, program-load and instruction-out bundle between the sequencer and the fetch stage.
interface instr_fetch_if #(
  parameter int INSTR_WIDTH = 20,
  parameter int ADDR_BITS   = 5
);
  logic                   start;
  logic                   stop;
  logic                   load_en;
  logic [ADDR_BITS-1:0]   load_addr;
  logic [INSTR_WIDTH-1:0] load_data;
  logic [INSTR_WIDTH-1:0] instruction;
  logic                   instr_valid;
  logic [ADDR_BITS-1:0]   pc;
  logic                   busy;
  logic                   done;

  modport master (
    output start, stop, load_en, load_addr, load_data,
    input  instruction, instr_valid, pc, busy, done
  );

  modport slave (
    input  start, stop, load_en, load_addr, load_data,
    output instruction, instr_valid, pc, busy, done
  );
endinterface

// File: rtl/instr_fetch_prog_mem.sv
// Program store: one synchronous write port, one synchronous read port, array not reset.
module prog_mem #(
  parameter int INSTR_WIDTH = 20,
  parameter int ADDR_BITS   = 5
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [ADDR_BITS-1:0]   waddr,
  input  logic [INSTR_WIDTH-1:0] wdata,
  input  logic                   re,
  input  logic [ADDR_BITS-1:0]   raddr,
  output logic [INSTR_WIDTH-1:0] rdata
);
  logic [INSTR_WIDTH-1:0] mem [2**ADDR_BITS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/instr_fetch.sv
// Walks the program store from address 0, holding each word for ISSUE_CYCLES clocks
// with a one-cycle NOP gap, until HALT, end of memory or stop.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int                     INSTR_WIDTH  = 20,
  parameter int                     ADDR_BITS    = 5,
  parameter int                     ISSUE_CYCLES = 3,
  parameter logic [OPC_W-1:0]       HALT_OPCODE  = DEF_HALT_OPCODE,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR    = INSTR_WIDTH'(DEF_NOP_INSTR)
) (
  input  logic          clk,
  input  logic          rst,
  instr_fetch_if.slave  bus
);
  localparam int                   CNT_W    = (ISSUE_CYCLES > 1) ? $clog2(ISSUE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(ISSUE_CYCLES - 1);
  localparam logic [ADDR_BITS-1:0] PC_LAST  = '1;

  logic [1:0]             state_q, state_d;
  logic [ADDR_BITS-1:0]   pc_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [INSTR_WIDTH-1:0] rdata;
  logic                   idle_like, go, mem_we, is_halt, last_beat;

  // Load takes priority over start when both arrive in IDLE/DONE.
  assign idle_like = (state_q == S_IDLE) || (state_q == S_DONE);
  assign go        = idle_like && bus.start && !bus.load_en;
  assign mem_we    = idle_like && bus.load_en;
  assign is_halt   = (rdata[INSTR_WIDTH-1 -: OPC_W] == HALT_OPCODE);
  assign last_beat = (cnt_q == CNT_LAST);

  prog_mem #(
    .INSTR_WIDTH (INSTR_WIDTH),
    .ADDR_BITS   (ADDR_BITS)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (bus.load_addr),
    .wdata (bus.load_data),
    .re    (state_q == S_FETCH),
    .raddr (pc_q),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (go) state_d = S_FETCH;
      S_FETCH:        state_d = bus.stop ? S_DONE : S_ISSUE;
      S_ISSUE: begin
        if (bus.stop || is_halt) state_d = S_DONE;
        else if (last_beat)      state_d = (pc_q == PC_LAST) ? S_DONE : S_FETCH;
      end
      default:        state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy        = (state_q == S_FETCH) || (state_q == S_ISSUE);
    bus.done        = (state_q == S_DONE);
    bus.instr_valid = (state_q == S_ISSUE) && !is_halt;
    bus.instruction = bus.instr_valid ? rdata : NOP_INSTR;
    bus.pc          = pc_q;
  end

  // The counter wraps harmlessly on the exit beat; FETCH always re-zeroes it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (go)                                            pc_q <= '0;
      else if (state_q == S_ISSUE && state_d == S_FETCH) pc_q <= pc_q + ADDR_BITS'(1);
      if (state_q == S_FETCH)      cnt_q <= '0;
      else if (state_q == S_ISSUE) cnt_q <= cnt_q + CNT_W'(1);
    end
  end
endmodule
